rtype_instr_encoder: RTL and testbench
======================================

Name: rtype_instr_encoder

Overview:
- Encoder counterpart of the single-cycle control unit's decoder.
- Accepts R-type operation requests over a valid/ready handshake: ALU op code, rd, rs1 and rs2.
- Packs each request into a 32-bit RV32I R-type instruction word and writes it sequentially into instruction memory through a registered write port.
- Used as the program loader/self-test generator ahead of the single-cycle core; its output words decode back to the same aluControl and regFileWe=1.

Parameters:
- ADDR_WIDTH, 6, word-address width of the instruction memory; depth = 2**ADDR_WIDTH words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load session from BASE_ADDR.
- reqValid  input  1  request valid.
- reqReady  output  1  encoder can accept a request this cycle.
- reqAluControl  input  4  {funct7[5], funct3}, same encoding as the shared ALU op constants.
- reqRd  input  5  destination register.
- reqRs1  input  5  source register 1.
- reqRs2  input  5  source register 2.
- reqLast  input  1  marks the final request of the session.
- memWe  output  1  instruction memory write enable.
- memAddr  output  ADDR_WIDTH  word address.
- memWData  output  32  encoded instruction.
- busy  output  1  state is LOAD or a write is pending.
- done  output  1  session finished; held until the next start.
- full  output  1  session ended because the last memory word was written.
- illegal  output  1  sticky; an illegal aluControl was received this session.
- wordCount  output  ADDR_WIDTH+1  words written this session.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - memWe=0, memAddr=BASE_ADDR, memWData=0.
  - reqReady=0, busy=0, done=0, full=0, illegal=0, wordCount=0.
- FSM states: IDLE, LOAD, DONE.
  - IDLE/DONE + start -> LOAD. Write pointer = BASE_ADDR; wordCount, done, full and illegal cleared.
  - start while in LOAD is ignored.
- reqReady = (state==LOAD) && !pointer_exhausted. Combinational from registered state only; it must not depend on reqValid.
- A transfer occurs when reqValid && reqReady.
- Encoding of an accepted request:
  - [6:0] = 7'b0110011.
  - [11:7] = rd.
  - [14:12] = aluControl[2:0].
  - [19:15] = rs1.
  - [24:20] = rs2.
  - [31:25] = {1'b0, aluControl[3], 5'b0}.
- Legal aluControl values:
  - aluControl[3]=0: any funct3.
  - aluControl[3]=1: only funct3 000 (SUB) or 101 (SRA).
- Latency: a legal transfer in cycle N gives memWe=1 in cycle N+1, with memAddr = pointer and memWData = the encoded word. The pointer and wordCount increment in cycle N+1. Sustained throughput is 1 word/cycle.
- Illegal request: accepted (the handshake completes) but not written. memWe stays 0, the pointer does not advance, illegal is set.
- reqLast on a transfer: after that transfer, LOAD -> DONE. Any write for it still completes in N+1. done=1 from cycle N+1.
- reqLast on an illegal request still ends the session.
- Exhaustion: a legal transfer targeting address 2**ADDR_WIDTH-1 forces LOAD -> DONE with full=1, even without reqLast.
- Pointer wrap-around is never performed.
- BASE_ADDR>0 reduces capacity accordingly.
- memWe is 0 in every cycle without a pending write.
- reset_n deasserted mid-session: everything returns to reset values immediately. Any pending write is dropped; memWe is forced to 0 asynchronously.
- busy = (state==LOAD) || memWe.

Decomposition:
- Shared package (the existing defines):
  - R-type opcode constant.
  - ALU op codes ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - Field-position localparams.
  - Encoder state enum.
- One natural sub-module: rtype_field_packer. Combinational; takes aluControl, rd, rs1 and rs2, and produces the instruction word plus a legal flag. It is reusable by the bench's reference model.

Test Plan:
- start, then 4 back-to-back requests (ADD x1,x2,x3; SUB x4,x5,x6; SRA x7,x8,x9 with reqLast on the 4th: OR x10,x11,x12):
  - memWe pulses in 4 consecutive cycles at addresses 0..3.
  - Words 0x003100B3, 0x40628233, 0x409453B3, 0x00C5E533.
  - done=1, wordCount=4.
- reqValid toggled every other cycle, with reqReady checked independent of reqValid:
  - Writes occur exactly 1 cycle after each transfer.
  - No gaps or duplicates.
- Illegal aluControl 4'b1001 between two legal ADDs:
  - Only 2 writes, at addresses 0 and 1.
  - illegal=1 sticky until the next start.
- ADDR_WIDTH=2, 5 requests without reqLast:
  - 4 writes (addresses 0..3).
  - full=1, done=1, reqReady=0.
  - The 5th request is never accepted.
- reset_n pulled low in the cycle after a transfer:
  - memWe=0 immediately.
  - All outputs at reset values.
  - A fresh start begins at BASE_ADDR.
- Encoded words decoded by the control unit:
  - regFileWe=1 for every word.
  - aluControl equals the original reqAluControl for all 10 legal ops.

Source files
------------

// File: rtl/rtype_instr_encoder_pkg.sv
// Shared definitions for the R-type instruction encoder.
// Contents:
//   - RV32I R-type opcode and instruction field positions
//   - ALU op codes, encoded as {funct7[5], funct3}
//   - Encoder FSM state enum
//   - alu_op_legal(): whether an ALU op code has an R-type encoding
package rtype_instr_encoder_pkg;

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

  // Only SUB and SRA use the funct7[5] alternate encoding in RV32I.
  function automatic logic alu_op_legal(input logic [3:0] op);
    return !op[3] || (op == ALU_SUB) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/rtype_field_packer.sv
// Combinational packer: builds a 32-bit RV32I R-type instruction word.
// Ports:
//   alu_control  in  4   {funct7[5], funct3}
//   rd/rs1/rs2   in  5   register numbers
//   word         out 32  encoded instruction
//   legal        out 1   alu_control has a valid R-type encoding
module rtype_field_packer
  import rtype_instr_encoder_pkg::*;
(
  input  logic [3:0]  alu_control,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word                    = '0;
    word[OPCODE_LSB +: 7]   = OPCODE_RTYPE;
    word[RD_LSB     +: 5]   = rd;
    word[FUNCT3_LSB +: 3]   = alu_control[2:0];
    word[RS1_LSB    +: 5]   = rs1;
    word[RS2_LSB    +: 5]   = rs2;
    word[FUNCT7_LSB +: 7]   = {1'b0, alu_control[3], 5'b0};
    legal                   = alu_op_legal(alu_control);
  end

endmodule

// File: rtl/rtype_instr_encoder.sv
// R-type instruction encoder / program loader.
// Accepts ALU op requests over valid/ready, encodes each legal one into an
// RV32I R-type word and writes it to consecutive instruction memory words,
// starting at BASE_ADDR after each start pulse.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 begin a load session (ignored while loading)
//   reqValid/reqReady     request handshake
//   reqAluControl/reqRd/reqRs1/reqRs2/reqLast  request payload
//   memWe/memAddr/memWData  registered instruction memory write port
//   busy, done, full, illegal, wordCount  session status
module rtype_instr_encoder
  import rtype_instr_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [3:0]            reqAluControl,
  input  logic [4:0]            reqRd,
  input  logic [4:0]            reqRs1,
  input  logic [4:0]            reqRs2,
  input  logic                  reqLast,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memWData,
  output logic                  busy,
  output logic                  done,
  output logic                  full,
  output logic                  illegal,
  output logic [ADDR_WIDTH:0]   wordCount
);

  localparam logic [ADDR_WIDTH:0]   BASE_PTR  = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE_WORD = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   PTR_ONE   = (ADDR_WIDTH+1)'(1);

  enc_state_e state, state_next;

  // One extra MSB so that running past the last word is visible as a flag
  // instead of wrapping back to address 0.
  logic [ADDR_WIDTH:0] ptr;
  logic                ptr_exhausted;
  logic                at_last;

  logic [31:0] packed_word;
  logic        op_legal;
  logic        xfer;
  logic        write_now;
  logic        session_start;

  rtype_field_packer u_packer (
    .alu_control (reqAluControl),
    .rd          (reqRd),
    .rs1         (reqRs1),
    .rs2         (reqRs2),
    .word        (packed_word),
    .legal       (op_legal)
  );

  assign ptr_exhausted = ptr[ADDR_WIDTH];
  assign at_last       = (ptr[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});

  assign reqReady      = (state == ST_LOAD) && !ptr_exhausted;
  assign xfer          = reqValid && reqReady;
  assign write_now     = xfer && op_legal;
  assign session_start = start && (state != ST_LOAD);

  assign done = (state == ST_DONE);
  assign busy = (state == ST_LOAD) || memWe;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        // An illegal op never consumes the last address, so only a legal
        // write there exhausts the memory.
        if (xfer && (reqLast || (op_legal && at_last))) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      memWe     <= 1'b0;
      memAddr   <= BASE_WORD;
      memWData  <= '0;
      ptr       <= BASE_PTR;
      wordCount <= '0;
      full      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      memWe <= write_now;
      if (session_start) begin
        ptr       <= BASE_PTR;
        wordCount <= '0;
        full      <= 1'b0;
        illegal   <= 1'b0;
      end
      if (write_now) begin
        memAddr   <= ptr[ADDR_WIDTH-1:0];
        memWData  <= packed_word;
        ptr       <= ptr + PTR_ONE;
        wordCount <= wordCount + PTR_ONE;
        if (at_last) full <= 1'b1;
      end
      if (xfer && !op_legal) illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rtype_instr_encoder.sv
// Testbench for rtype_instr_encoder: two instances (64-word and 4-word
// memories), scoreboard queues filled on accepted requests, and a monitor
// that checks every memory write against them.
module tb_rtype_instr_encoder;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          alu;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  logic        start_s[2];
  logic        req_valid[2];
  logic        req_last[2];
  logic [3:0]  req_alu[2];
  logic [4:0]  req_rd[2];
  logic [4:0]  req_rs1[2];
  logic [4:0]  req_rs2[2];

  logic        ready_o[2];
  logic        we_o[2];
  logic        busy_o[2];
  logic        done_o[2];
  logic        full_o[2];
  logic        illegal_o[2];
  logic [31:0] wdata_o[2];
  logic [5:0]  addr0;
  logic [6:0]  wc0;
  logic [1:0]  addr1;
  logic [2:0]  wc1;

  int checks = 0;
  int errors = 0;
  int cyc_count = 0;

  exp_t q0[$];
  exp_t q1[$];

  int m_ptr[2];
  int m_count[2];
  bit m_load[2];
  bit m_done[2];
  bit m_full[2];
  bit m_illegal[2];
  int depth[2] = '{64, 4};

  rtype_instr_encoder #(.ADDR_WIDTH(6), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start_s[0]),
    .reqValid(req_valid[0]), .reqReady(ready_o[0]),
    .reqAluControl(req_alu[0]), .reqRd(req_rd[0]), .reqRs1(req_rs1[0]),
    .reqRs2(req_rs2[0]), .reqLast(req_last[0]),
    .memWe(we_o[0]), .memAddr(addr0), .memWData(wdata_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .full(full_o[0]),
    .illegal(illegal_o[0]), .wordCount(wc0)
  );

  rtype_instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_s[1]),
    .reqValid(req_valid[1]), .reqReady(ready_o[1]),
    .reqAluControl(req_alu[1]), .reqRd(req_rd[1]), .reqRs1(req_rs1[1]),
    .reqRs2(req_rs2[1]), .reqLast(req_last[1]),
    .memWe(we_o[1]), .memAddr(addr1), .memWData(wdata_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .full(full_o[1]),
    .illegal(illegal_o[1]), .wordCount(wc1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_count <= cyc_count + 1;

  function automatic int get_addr(input int idx);
    return (idx == 0) ? int'(addr0) : int'(addr1);
  endfunction

  function automatic int get_wc(input int idx);
    return (idx == 0) ? int'(wc0) : int'(wc1);
  endfunction

  // Reference encoding by field arithmetic.
  function automatic logic [31:0] ref_word(input int alu, input int rd, input int rs1, input int rs2);
    int w;
    w = 51 + rd * 128 + (alu % 8) * 4096 + rs1 * 32768 + rs2 * 1048576 + (alu / 8) * 1073741824;
    return 32'(w);
  endfunction

  function automatic bit ref_legal(input int alu);
    return (alu < 8) || (alu == 8) || (alu == 13);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_start(input int idx);
    if (!m_load[idx]) begin
      m_load[idx] = 1; m_done[idx] = 0; m_full[idx] = 0; m_illegal[idx] = 0;
      m_ptr[idx] = 0; m_count[idx] = 0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_load[i] = 0; m_done[i] = 0; m_full[i] = 0; m_illegal[i] = 0;
      m_ptr[i] = 0; m_count[i] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_apply(input int idx, input int alu, input int rd, input int rs1, input int rs2, input bit last);
    exp_t e;
    if (ref_legal(alu)) begin
      e.addr = m_ptr[idx];
      e.data = ref_word(alu, rd, rs1, rs2);
      e.alu  = alu;
      e.cyc  = cyc_count;
      if (idx == 0) q0.push_back(e); else q1.push_back(e);
      if (m_ptr[idx] == depth[idx] - 1) begin
        m_full[idx] = 1;
        m_load[idx] = 0;
        m_done[idx] = 1;
      end
      m_ptr[idx]++;
      m_count[idx]++;
    end else begin
      m_illegal[idx] = 1;
    end
    if (last) begin
      m_load[idx] = 0;
      m_done[idx] = 1;
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic applyStimulus(input int idx, input bit v, input int alu, input int rd,
                               input int rs1, input int rs2, input bit last);
    bit rdy;
    req_valid[idx] = v;
    req_alu[idx]   = 4'(alu);
    req_rd[idx]    = 5'(rd);
    req_rs1[idx]   = 5'(rs1);
    req_rs2[idx]   = 5'(rs2);
    req_last[idx]  = last;
    @(negedge clk);
    rdy = ready_o[idx];
    chk($sformatf("reqReady%0d", idx), 32'(ready_o[idx]),
        32'(m_load[idx] && (m_ptr[idx] < depth[idx])));
    @(posedge clk);
    #1;
    if (v && rdy) model_apply(idx, alu, rd, rs1, rs2, last);
    req_valid[idx] = 1'b0;
    req_last[idx]  = 1'b0;
  endtask

  task automatic idle(input int idx);
    applyStimulus(idx, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic pulseStart(input int idx);
    start_s[idx] = 1'b1;
    @(posedge clk);
    #1;
    start_s[idx] = 1'b0;
    model_start(idx);
  endtask

  task automatic checkOutput(input int idx);
    @(negedge clk);
    chk($sformatf("done%0d", idx), 32'(done_o[idx]), 32'(m_done[idx]));
    chk($sformatf("full%0d", idx), 32'(full_o[idx]), 32'(m_full[idx]));
    chk($sformatf("illegal%0d", idx), 32'(illegal_o[idx]), 32'(m_illegal[idx]));
    chk($sformatf("wordCount%0d", idx), 32'(get_wc(idx)), 32'(m_count[idx]));
    chk($sformatf("busy%0d", idx), 32'(busy_o[idx]), 32'(m_load[idx]));
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input int idx);
    chk($sformatf("rst_memWe%0d", idx), 32'(we_o[idx]), 0);
    chk($sformatf("rst_memAddr%0d", idx), 32'(get_addr(idx)), 0);
    chk($sformatf("rst_memWData%0d", idx), wdata_o[idx], 0);
    chk($sformatf("rst_reqReady%0d", idx), 32'(ready_o[idx]), 0);
    chk($sformatf("rst_busy%0d", idx), 32'(busy_o[idx]), 0);
    chk($sformatf("rst_done%0d", idx), 32'(done_o[idx]), 0);
    chk($sformatf("rst_full%0d", idx), 32'(full_o[idx]), 0);
    chk($sformatf("rst_illegal%0d", idx), 32'(illegal_o[idx]), 0);
    chk($sformatf("rst_wordCount%0d", idx), 32'(get_wc(idx)), 0);
  endtask

  // Monitor: every write must match the oldest expected entry, one cycle
  // after its transfer; an entry whose cycle passes without a write is missed.
  task automatic monitor(input int idx, input bit we, input int addr, input logic [31:0] data);
    exp_t e;
    bit have;
    have = (idx == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) begin
      if (idx == 0) e = q0[0]; else e = q1[0];
    end
    if (we) begin
      if (!have) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_write%0d actual=addr %0d data %0h required=no write", idx, addr, data);
      end else begin
        if (idx == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        chk($sformatf("memAddr%0d", idx), 32'(addr), 32'(e.addr));
        chk($sformatf("memWData%0d", idx), data, e.data);
        chk($sformatf("write_latency%0d", idx), 32'(cyc_count), 32'(e.cyc));
        chk($sformatf("decode_regFileWe%0d", idx), 32'(data[6:0] == 7'b0110011), 1);
        chk($sformatf("decode_aluControl%0d", idx), 32'({data[30], data[14:12]}), 32'(e.alu));
      end
    end else if (have && (e.cyc <= cyc_count)) begin
      checks++; errors++;
      $display("[TB] FAIL missing_write%0d actual=no write required=addr %0d data %0h", idx, e.addr, e.data);
      if (idx == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    monitor(0, we_o[0], get_addr(0), wdata_o[0]);
    monitor(1, we_o[1], get_addr(1), wdata_o[1]);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int t1_alu[4] = '{0, 8, 13, 6};
  int t1_rd[4]  = '{1, 4, 7, 10};
  int t1_rs1[4] = '{2, 5, 8, 11};
  int t1_rs2[4] = '{3, 6, 9, 12};
  int t2_alu[6] = '{1, 2, 3, 4, 5, 7};

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 0; req_valid[i] = 0; req_last[i] = 0;
      req_alu[i] = 0; req_rd[i] = 0; req_rs1[i] = 0; req_rs2[i] = 0;
    end
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    checkReset(0);
    checkReset(1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] back-to-back ADD/SUB/SRA/OR");
    pulseStart(0);
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1'b1, t1_alu[i], t1_rd[i], t1_rs1[i], t1_rs2[i], i == 3);
    idle(0);
    checkOutput(0);

    $display("[TB] valid every other cycle");
    pulseStart(0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1'b1, t2_alu[i], $urandom % 32, $urandom % 32, $urandom % 32, i == 5);
      idle(0);
    end
    checkOutput(0);

    $display("[TB] illegal op between two ADDs");
    pulseStart(0);
    applyStimulus(0, 1'b1, 0, 1, 2, 3, 1'b0);
    applyStimulus(0, 1'b1, 9, 4, 5, 6, 1'b0);
    applyStimulus(0, 1'b1, 0, 7, 8, 9, 1'b1);
    idle(0);
    checkOutput(0);
    checkOutput(0);
    pulseStart(0);
    checkOutput(0);
    applyStimulus(0, 1'b1, 0, 1, 1, 1, 1'b1);
    idle(0);

    $display("[TB] exhaustion on 4-word memory");
    pulseStart(1);
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 1'b1, 0, i + 1, i + 2, i + 3, 1'b0);
    idle(1);
    checkOutput(1);

    $display("[TB] reset after a transfer");
    pulseStart(0);
    applyStimulus(0, 1'b1, 4, 3, 2, 1, 1'b0);
    reset_n = 1'b0;
    #1;
    checkReset(0);
    checkReset(1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    pulseStart(0);
    applyStimulus(0, 1'b1, 7, 5, 6, 7, 1'b1);
    idle(0);
    checkOutput(0);

    $display("[TB] random sessions");
    for (int s = 0; s < 12; s++) begin
      int idx;
      int len;
      idx = s % 2;
      len = int'($urandom_range(1, 8));
      pulseStart(idx);
      for (int k = 0; k < len; k++)
        applyStimulus(idx, ($urandom % 4) != 0, int'($urandom % 16), int'($urandom % 32),
                      int'($urandom % 32), int'($urandom % 32), k == len - 1);
      idle(idx);
      checkOutput(idx);
    end

    repeat (3) idle(0);
    chk("pending_writes0", 32'(q0.size()), 0);
    chk("pending_writes1", 32'(q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
